// File: rtl/l2_writeback_buffer_pkg.sv
// l2_writeback_buffer_pkg: shared line/address types for the L2 writeback buffer.
package l2_writeback_buffer_pkg;
    localparam int LINESIZE = 128;
    localparam int OFFSET_BITS = $clog2(LINESIZE / 8);
    localparam int TAG_BITS = 16 - OFFSET_BITS;
    typedef logic [15:0] lc3b_word;
    typedef logic [LINESIZE-1:0] l2_line_t;
    typedef logic [TAG_BITS-1:0] line_tag_t;
    function automatic line_tag_t line_of(lc3b_word a);
        return a[15:OFFSET_BITS];
    endfunction
endpackage

// File: rtl/l2_writeback_buffer_if.sv
// l2_writeback_buffer_if: L2-side and pmem-side buses of the writeback buffer.
interface l2_writeback_buffer_if;
    import l2_writeback_buffer_pkg::*;
    logic l2_read, l2_write, l2_resp;
    lc3b_word l2_address;
    l2_line_t l2_wdata, l2_rdata;
    logic pmem_read, pmem_write, pmem_resp;
    lc3b_word pmem_address;
    l2_line_t pmem_wdata, pmem_rdata;
    modport slave(
        input l2_read, l2_write, l2_address, l2_wdata, pmem_rdata, pmem_resp,
        output l2_rdata, l2_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
    modport master(
        output l2_read, l2_write, l2_address, l2_wdata, pmem_rdata, pmem_resp,
        input l2_rdata, l2_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/l2_writeback_buffer_fifo.sv
// wb_fifo_cam: depth-entry line FIFO with parallel address match and in-place overwrite.
module wb_fifo_cam
    import l2_writeback_buffer_pkg::*;
#(
    parameter int depth = 2,
    localparam int IW = $clog2(depth)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  line_tag_t     lookup_tag,
    input  logic          push,
    input  line_tag_t     push_tag,
    input  l2_line_t      push_data,
    input  logic          pop,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  l2_line_t      wr_data,
    output logic          match,
    output logic [IW-1:0] match_idx,
    output logic [IW-1:0] head_idx,
    output logic [IW:0]   count,
    output l2_line_t      match_data,
    output l2_line_t      head_data,
    output line_tag_t     head_tag
);
    logic [depth-1:0] valid;
    line_tag_t tags [depth];
    l2_line_t data [depth];
    logic [IW-1:0] tail;
    always_comb begin
        match = 1'b0;
        match_idx = '0;
        for (int i = 0; i < depth; i++)
            if (valid[i] && tags[i] == lookup_tag) begin
                match = 1'b1;
                match_idx = IW'(i);
            end
    end
    assign match_data = data[match_idx];
    assign head_data = data[head_idx];
    assign head_tag = tags[head_idx];
    // payload storage needs no reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (push) begin
            tags[tail] <= push_tag;
            data[tail] <= push_data;
        end
        if (wr_en) data[wr_idx] <= wr_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            head_idx <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail <= tail + 1'b1;
            end
            if (pop) begin
                valid[head_idx] <= 1'b0;
                head_idx <= head_idx + 1'b1;
            end
            count <= count + (IW+1)'(push) - (IW+1)'(pop);
        end
    end
endmodule

// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: buffers L2 evictions, forwards/serves L2 reads, drains lines to pmem when idle.
module l2_writeback_buffer
    import l2_writeback_buffer_pkg::*;
#(
    parameter int depth = 2
) (
    input logic clk,
    input logic rst_n,
    l2_writeback_buffer_if.slave bus
);
    localparam int IW = $clog2(depth);
    localparam logic [IW:0] FULL = (IW+1)'(depth);
    localparam logic [1:0] IDLE = 2'd0, PREAD = 2'd1, DRAIN = 2'd2, RESP = 2'd3;
    logic [1:0] state;
    logic match, idle, rd_hit, rd_miss, coalesce, push, drain, pop;
    logic [IW-1:0] match_idx, head_idx;
    logic [IW:0] count;
    l2_line_t match_data, head_data;
    line_tag_t head_tag, req_tag;
    // the cycle l2_resp is high the requester still holds its request, so IDLE ignores it
    always_comb begin
        req_tag = line_of(bus.l2_address);
        idle = state == IDLE && !bus.l2_resp;
        rd_hit = idle && bus.l2_read && match;
        rd_miss = idle && bus.l2_read && !match;
        coalesce = idle && bus.l2_write && match && (match_idx != head_idx || count > (IW+1)'(1));
        push = idle && bus.l2_write && !match && count < FULL;
        drain = idle && !bus.l2_read && !coalesce && !push && count != '0;
        pop = state == DRAIN && bus.pmem_resp;
    end
    wb_fifo_cam #(.depth(depth)) u_fifo (
        .clk(clk), .rst_n(rst_n), .lookup_tag(req_tag),
        .push(push), .push_tag(req_tag), .push_data(bus.l2_wdata), .pop(pop),
        .wr_en(coalesce), .wr_idx(match_idx), .wr_data(bus.l2_wdata),
        .match(match), .match_idx(match_idx), .head_idx(head_idx), .count(count),
        .match_data(match_data), .head_data(head_data), .head_tag(head_tag)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bus.l2_resp <= 1'b0;
            bus.l2_rdata <= '0;
            bus.pmem_read <= 1'b0;
            bus.pmem_write <= 1'b0;
            bus.pmem_address <= '0;
            bus.pmem_wdata <= '0;
        end else begin
            bus.l2_resp <= state == RESP;
            case (state)
                IDLE: begin
                    if (rd_hit) begin
                        bus.l2_rdata <= match_data;
                        state <= RESP;
                    end else if (rd_miss) begin
                        bus.pmem_read <= 1'b1;
                        bus.pmem_address <= {req_tag, {OFFSET_BITS{1'b0}}};
                        state <= PREAD;
                    end else if (coalesce || push) begin
                        state <= RESP;
                    end else if (drain) begin
                        bus.pmem_write <= 1'b1;
                        bus.pmem_address <= {head_tag, {OFFSET_BITS{1'b0}}};
                        bus.pmem_wdata <= head_data;
                        state <= DRAIN;
                    end
                end
                PREAD: if (bus.pmem_resp) begin
                    bus.pmem_read <= 1'b0;
                    bus.l2_rdata <= bus.pmem_rdata;
                    state <= RESP;
                end
                DRAIN: if (bus.pmem_resp) begin
                    bus.pmem_write <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: directed and random L2/pmem traffic checked against a queue-based buffer model.
module tb_l2_writeback_buffer;
    import l2_writeback_buffer_pkg::*;
    typedef struct {
        logic [11:0] line;
        l2_line_t data;
    } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    int lat = 2;
    int pcnt = 0;
    l2_line_t mem [4096];
    ent_t q[$];
    logic [15:0] drained[$];
    logic hold = 1'b0;
    logic prev_resp = 1'b0;
    logic [17:0] prev_req;
    l2_line_t prev_wd;
    logic pread_seen = 1'b0;
    logic [15:0] last_pread = '0;
    always #5 clk = ~clk;
    l2_writeback_buffer_if bus();
    l2_writeback_buffer #(.depth(2)) dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    function automatic l2_line_t init_line(logic [11:0] l);
        return {4{4'h0, l, 16'hC0DE}};
    endfunction

    function automatic int find(logic [11:0] l);
        foreach (q[i]) if (q[i].line == l) return i;
        return -1;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic l2_req(input logic rd, input logic [15:0] a, input l2_line_t d,
                          output l2_line_t rdata, output int cyc);
        bus.l2_read = rd;
        bus.l2_write = !rd;
        bus.l2_address = a;
        bus.l2_wdata = d;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.l2_resp) break;
        end
        if (!bus.l2_resp) chk("l2_resp_timeout", bus.l2_resp, 1);
        rdata = bus.l2_rdata;
        @(posedge clk);
        #1;
        bus.l2_read = 1'b0;
        bus.l2_write = 1'b0;
    endtask

    task automatic wait_drained();
        int k;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !bus.pmem_write && !bus.pmem_read) break;
        end
        if (k == 1000) chk("drain_timeout", bus.pmem_write, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                pcnt = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                pcnt++;
                if (pcnt >= lat) begin
                    bus.pmem_resp = 1'b1;
                    bus.pmem_rdata = mem[bus.pmem_address[15:4]];
                end
            end
        end
    end

    // per-cycle compare against the transaction-level model
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("pmem_exclusive", bus.pmem_read && bus.pmem_write, 0);
            if (bus.pmem_read || bus.pmem_write) chk("pmem_align", bus.pmem_address[3:0], 0);
            if (hold) begin
                chk("pmem_hold", {bus.pmem_read, bus.pmem_write, bus.pmem_address}, prev_req);
                if (prev_req[16]) chk("pmem_wdata_hold", bus.pmem_wdata, prev_wd);
            end
            hold = (bus.pmem_read || bus.pmem_write) && !bus.pmem_resp;
            prev_req = {bus.pmem_read, bus.pmem_write, bus.pmem_address};
            prev_wd = bus.pmem_wdata;
            if (bus.pmem_read) begin
                pread_seen = 1'b1;
                last_pread = bus.pmem_address;
            end
            if (bus.pmem_write && bus.pmem_resp) begin
                chk("drain_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("drain_addr", bus.pmem_address, {q[0].line, 4'h0});
                    chk("drain_data", bus.pmem_wdata, q[0].data);
                    void'(q.pop_front());
                end
                mem[bus.pmem_address[15:4]] = bus.pmem_wdata;
                drained.push_back(bus.pmem_address);
            end
            if (bus.pmem_read && bus.pmem_resp) begin
                chk("pread_not_buffered", find(bus.l2_address[15:4]) >= 0, 0);
                chk("pread_addr", bus.pmem_address, {bus.l2_address[15:4], 4'h0});
            end
            if (bus.l2_resp) begin
                int idx;
                chk("resp_pulse", prev_resp, 0);
                idx = find(bus.l2_address[15:4]);
                if (bus.l2_read) begin
                    if (idx >= 0) chk("read_fwd_data", bus.l2_rdata, q[idx].data);
                    else chk("read_mem_data", bus.l2_rdata, mem[bus.l2_address[15:4]]);
                end else if (bus.l2_write) begin
                    if (idx >= 0) q[idx].data = bus.l2_wdata;
                    else q.push_back('{bus.l2_address[15:4], bus.l2_wdata});
                    chk("occupancy", q.size() <= 2, 1);
                end
            end
            prev_resp = bus.l2_resp;
        end else begin
            q.delete();
            hold = 1'b0;
            prev_resp = 1'b0;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        l2_line_t rd;
        int cyc;
        bus.l2_read = 1'b0;
        bus.l2_write = 1'b0;
        bus.l2_address = '0;
        bus.l2_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = init_line(12'(i));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_l2_resp", bus.l2_resp, 0);
        chk("rst_l2_rdata", bus.l2_rdata, 0);
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        chk("rst_pmem_address", bus.pmem_address, 0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 0);
        chk("rst_count", dut.u_fifo.count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lat = 3;
        drained.delete();
        l2_req(1'b0, 16'h1230, {4{32'hAAAA_0001}}, rd, cyc);
        chk("wr_latency", cyc, 2);
        chk("wr_no_pmem", bus.pmem_read | bus.pmem_write, 0);
        wait_drained();
        chk("drain1_n", drained.size(), 1);
        chk("drain1_addr", drained[0], 16'h1230);
        chk("drain1_data", mem[12'h123], {4{32'hAAAA_0001}});
        chk("drain1_count", dut.u_fifo.count, 0);
        lat = 20;
        l2_req(1'b0, 16'h4000, {4{32'hBBBB_0002}}, rd, cyc);
        pread_seen = 1'b0;
        l2_req(1'b1, 16'h4008, '0, rd, cyc);
        chk("fwd_data", rd, {4{32'hBBBB_0002}});
        chk("fwd_latency", cyc, 2);
        chk("fwd_no_pread", pread_seen, 0);
        wait_drained();
        lat = 4;
        drained.delete();
        l2_req(1'b0, 16'h1000, {4{32'h1111_1000}}, rd, cyc);
        l2_req(1'b0, 16'h2000, {4{32'h2222_2000}}, rd, cyc);
        chk("full_count", dut.u_fifo.count, 2);
        l2_req(1'b0, 16'h3000, {4{32'h3333_3000}}, rd, cyc);
        chk("full_wr_latency", cyc, 7);
        chk("full_first_drain_n", drained.size(), 1);
        chk("full_first_drain", drained[0], 16'h1000);
        wait_drained();
        chk("full_order_n", drained.size(), 3);
        chk("full_order_1", drained[1], 16'h2000);
        chk("full_order_2", drained[2], 16'h3000);
        chk("full_data_2", mem[12'h300], {4{32'h3333_3000}});
        drained.delete();
        l2_req(1'b0, 16'h5000, {4{32'hCCCC_5000}}, rd, cyc);
        l2_req(1'b0, 16'h6000, {4{32'h0BAD_6000}}, rd, cyc);
        l2_req(1'b0, 16'h6000, {4{32'hDDDD_6000}}, rd, cyc);
        chk("coal_latency", cyc, 2);
        chk("coal_count", dut.u_fifo.count, 2);
        wait_drained();
        chk("coal_drain_n", drained.size(), 2);
        chk("coal_drain_0", drained[0], 16'h5000);
        chk("coal_drain_1", drained[1], 16'h6000);
        chk("coal_data", mem[12'h600], {4{32'hDDDD_6000}});
        lat = 5;
        mem[12'h700] = {4{32'h7777_ABCD}};
        pread_seen = 1'b0;
        l2_req(1'b1, 16'h7000, '0, rd, cyc);
        chk("miss_latency", cyc, 7);
        chk("miss_data", rd, {4{32'h7777_ABCD}});
        chk("miss_pread_seen", pread_seen, 1);
        chk("miss_pread_addr", last_pread, 16'h7000);
        lat = 50;
        l2_req(1'b0, 16'h8000, {4{32'hEEEE_8000}}, rd, cyc);
        for (int k = 0; k < 100 && !bus.pmem_write; k++) @(negedge clk);
        chk("rst_drain_started", bus.pmem_write, 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pmem_write", bus.pmem_write, 0);
        chk("rst_mid_count", dut.u_fifo.count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_state", dut.state, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_drain", bus.pmem_write, 0);
        chk("rst_no_commit", mem[12'h800], init_line(12'h800));
        for (int t = 0; t < 400; t++) begin
            lat = $urandom_range(1, 4);
            l2_req($urandom_range(0, 1) == 1,
                   {12'h100 + 12'($urandom_range(0, 5)), 4'($urandom)},
                   {$urandom, $urandom, $urandom, $urandom}, rd, cyc);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drained();
        chk("final_count", dut.u_fifo.count, q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
